// File: rtl/tcdm_req_buffer.sv
// rtl/tcdm_req_buffer.sv - elastic request buffer with outstanding-limit and drain control for one TCDM port
module tcdm_req_buffer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2,
    parameter int MAX_OUTST  = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    output logic                    clear_done_o,
    output logic                    busy_o,
    output logic                    err_o,
    input  logic                    s_req_i,
    input  logic [ADDR_WIDTH-1:0]   s_add_i,
    input  logic                    s_wen_i,
    input  logic [DATA_WIDTH-1:0]   s_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] s_be_i,
    output logic                    s_gnt_o,
    output logic                    s_r_valid_o,
    output logic [DATA_WIDTH-1:0]   s_r_rdata_o,
    output logic                    m_req_o,
    output logic [ADDR_WIDTH-1:0]   m_add_o,
    output logic                    m_wen_o,
    output logic [DATA_WIDTH-1:0]   m_wdata_o,
    output logic [DATA_WIDTH/8-1:0] m_be_o,
    input  logic                    m_gnt_i,
    input  logic                    m_r_valid_i,
    input  logic [DATA_WIDTH-1:0]   m_r_rdata_i
);

    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OUT_W    = $clog2(MAX_OUTST + 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] add_mem   [DEPTH];
    logic                  wen_mem   [DEPTH];
    logic [DATA_WIDTH-1:0] wdata_mem [DEPTH];
    logic [BE_WIDTH-1:0]   be_mem    [DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W:0]        wr_ptr_q, rd_ptr_q;
    logic [OUT_W-1:0]      outst_q;

    logic full, empty, outst_max, push, pop, drained;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign outst_max = (outst_q == OUT_W'(MAX_OUTST));

    // Handshakes depend only on registered state; rst_i forces both quiet while held.
    assign m_req_o = !rst_i && !empty && !outst_max;
    assign push    = s_req_i && s_gnt_o;
    assign pop     = m_req_o && m_gnt_i;
    assign drained = empty && (outst_q == '0) && !s_r_valid_o;

    assign m_add_o   = add_mem[rd_ptr_q[PTR_W-1:0]];
    assign m_wen_o   = wen_mem[rd_ptr_q[PTR_W-1:0]];
    assign m_wdata_o = wdata_mem[rd_ptr_q[PTR_W-1:0]];
    assign m_be_o    = be_mem[rd_ptr_q[PTR_W-1:0]];

    assign busy_o = !empty || (outst_q != '0) || s_r_valid_o;

    // Request storage; cleared on reset so the head outputs read zero while idle after reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                add_mem[i]   <= '0;
                wen_mem[i]   <= 1'b0;
                wdata_mem[i] <= '0;
                be_mem[i]    <= '0;
            end
        end else if (push) begin
            add_mem[wr_ptr_q[PTR_W-1:0]]   <= s_add_i;
            wen_mem[wr_ptr_q[PTR_W-1:0]]   <= s_wen_i;
            wdata_mem[wr_ptr_q[PTR_W-1:0]] <= s_wdata_i;
            be_mem[wr_ptr_q[PTR_W-1:0]]    <= s_be_i;
        end
    end

    // FIFO pointers advance independently, so a simultaneous push and pop keeps the count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Outstanding counter; a response with nothing outstanding latches the sticky error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outst_q <= '0;
            err_o   <= 1'b0;
        end else begin
            case ({pop, m_r_valid_i})
                2'b10: outst_q <= outst_q + OUT_W'(1);
                2'b01: begin
                    if (outst_q == '0) begin
                        err_o <= 1'b1;
                    end else begin
                        outst_q <= outst_q - OUT_W'(1);
                    end
                end
                default: outst_q <= outst_q;
            endcase
        end
    end

    // Response path is a plain one-cycle register; read data holds while valid is low.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s_r_valid_o <= 1'b0;
            s_r_rdata_o <= '0;
        end else begin
            s_r_valid_o <= m_r_valid_i;
            if (m_r_valid_i) begin
                s_r_rdata_o <= m_r_rdata_i;
            end
        end
    end

    // Drain/clear state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Drain/clear next state, upstream grant and completion pulse.
    always_comb begin
        state_d      = state_q;
        s_gnt_o      = 1'b0;
        clear_done_o = 1'b0;
        case (state_q)
            ST_RUN: begin
                s_gnt_o = !rst_i && !full;
                if (clear_i) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drained) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                clear_done_o = 1'b1;
                state_d      = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

endmodule

// File: tb/tb_tcdm_req_buffer.sv
// tb/tb_tcdm_req_buffer.sv - self-checking bench for tcdm_req_buffer
module tb_tcdm_req_buffer;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        clear_i = 1'b0;
    logic        clear_done_o, busy_o, err_o;
    logic        s_req_i = 1'b0;
    logic [31:0] s_add_i = '0;
    logic        s_wen_i = 1'b0;
    logic [31:0] s_wdata_i = '0;
    logic [3:0]  s_be_i = '0;
    logic        s_gnt_o, s_r_valid_o;
    logic [31:0] s_r_rdata_o;
    logic        m_req_o, m_wen_o;
    logic [31:0] m_add_o, m_wdata_o;
    logic [3:0]  m_be_o;
    logic        m_gnt_i = 1'b0;
    logic        m_r_valid_i = 1'b0;
    logic [31:0] m_r_rdata_i = '0;

    tcdm_req_buffer #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(2), .MAX_OUTST(4)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .clear_done_o(clear_done_o),
        .busy_o(busy_o), .err_o(err_o),
        .s_req_i(s_req_i), .s_add_i(s_add_i), .s_wen_i(s_wen_i), .s_wdata_i(s_wdata_i),
        .s_be_i(s_be_i), .s_gnt_o(s_gnt_o), .s_r_valid_o(s_r_valid_o), .s_r_rdata_o(s_r_rdata_o),
        .m_req_o(m_req_o), .m_add_o(m_add_o), .m_wen_o(m_wen_o), .m_wdata_o(m_wdata_o),
        .m_be_o(m_be_o), .m_gnt_i(m_gnt_i), .m_r_valid_i(m_r_valid_i), .m_r_rdata_i(m_r_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_err    = 0;
    int pop_cnt  = 0;
    int resp_pct = 100;
    logic sb_on     = 1'b0;
    logic auto_resp = 1'b0;

    logic [68:0] req_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] pend[$];

    typedef struct {
        logic        s_req;
        logic [31:0] s_add;
        logic        s_wen;
        logic        m_gnt;
        logic        r_valid;
        logic [31:0] r_rdata;
        logic        e_gnt;
        logic        e_mreq;
        logic [31:0] e_madd;
        logic        e_rv;
        logic [31:0] e_rdata;
        logic        e_busy;
    } vec_t;

    vec_t tbl[15];

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return ~a ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        logic [68:0] e;
        if (auto_resp && pend.size() > 0 && $urandom_range(0, 99) < resp_pct) begin
            m_r_valid_i = 1'b1;
            m_r_rdata_i = pend.pop_front();
        end
        if (sb_on && s_req_i && s_gnt_o) begin
            req_q.push_back({s_add_i, s_wen_i, s_wdata_i, s_be_i});
            exp_q.push_back(mem_model(s_add_i));
        end
        if (m_req_o && m_gnt_i) begin
            pop_cnt++;
            if (sb_on) begin
                if (req_q.size() == 0) begin
                    chk("req_unexpected", 1, 0);
                end else begin
                    e = req_q.pop_front();
                    chk("m_add", m_add_o, e[68:37]);
                    chk("m_attr", {m_wen_o, m_wdata_o, m_be_o}, e[36:0]);
                end
                pend.push_back(mem_model(m_add_o));
            end
        end
        @(posedge clk_i);
        @(negedge clk_i);
        m_r_valid_i = 1'b0;
        if (sb_on && s_r_valid_o) begin
            if (exp_q.size() == 0) chk("resp_unexpected", 1, 0);
            else chk("s_r_rdata", s_r_rdata_o, exp_q.pop_front());
        end
    endtask

    task automatic send_resp();
        m_r_valid_i = 1'b1;
        m_r_rdata_i = pend.pop_front();
    endtask

    task automatic drive_req(input logic [31:0] a, input logic w);
        s_req_i   = 1'b1;
        s_add_i   = a;
        s_wen_i   = w;
        s_wdata_i = a ^ 32'h1357_9BDF;
        s_be_i    = a[5:2];
    endtask

    task automatic drain(input string name);
        s_req_i   = 1'b0;
        m_gnt_i   = 1'b1;
        auto_resp = 1'b1;
        resp_pct  = 100;
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0 && pend.size() == 0 && !busy_o) break;
            tick();
        end
        chk({name, "_sb_empty"}, 64'(exp_q.size()), 0);
        chk({name, "_idle"}, busy_o, 0);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_gnt"}, s_gnt_o, 0);
        chk({name, "_mreq"}, m_req_o, 0);
        chk({name, "_madd"}, m_add_o, 0);
        chk({name, "_rv"}, s_r_valid_o, 0);
        chk({name, "_rdata"}, s_r_rdata_o, 0);
        chk({name, "_busy"}, busy_o, 0);
        chk({name, "_err"}, err_o, 0);
        chk({name, "_done"}, clear_done_o, 0);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 32'h100, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,   1'b0, 32'h0,         1'b0};
        tbl[1]  = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h100, 1'b0, 32'h0,         1'b1};
        tbl[2]  = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'hDEADBEEF,  1'b1, 1'b0, 32'h0,   1'b0, 32'h0,         1'b1};
        tbl[3]  = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,   1'b1, 32'hDEADBEEF,  1'b1};
        tbl[4]  = '{1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,   1'b0, 32'hDEADBEEF,  1'b0};
        tbl[5]  = '{1'b1, 32'h204, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h200, 1'b0, 32'hDEADBEEF,  1'b1};
        tbl[6]  = '{1'b1, 32'h208, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h200, 1'b0, 32'hDEADBEEF,  1'b1};
        tbl[7]  = '{1'b1, 32'h208, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 32'h200, 1'b0, 32'hDEADBEEF,  1'b1};
        tbl[8]  = '{1'b1, 32'h208, 1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h204, 1'b0, 32'hDEADBEEF,  1'b1};
        tbl[9]  = '{1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 1'b1, 32'h208, 1'b0, 32'hDEADBEEF,  1'b1};
        tbl[10] = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 32'h1,         1'b1, 1'b0, 32'h0,   1'b0, 32'hDEADBEEF,  1'b1};
        tbl[11] = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 32'h2,         1'b1, 1'b0, 32'h0,   1'b1, 32'h1,         1'b1};
        tbl[12] = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b1, 32'h3,         1'b1, 1'b0, 32'h0,   1'b1, 32'h2,         1'b1};
        tbl[13] = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,   1'b1, 32'h3,         1'b1};
        tbl[14] = '{1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,   1'b0, 32'h3,         1'b0};

        @(negedge clk_i);
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_i = 1'b0;
        tick();

        // Cycle-exact table: single read latency, then DEPTH=2 stall with head held.
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("tbl%0d_gnt", i), s_gnt_o, tbl[i].e_gnt);
            chk($sformatf("tbl%0d_mreq", i), m_req_o, tbl[i].e_mreq);
            if (tbl[i].e_mreq) chk($sformatf("tbl%0d_madd", i), m_add_o, tbl[i].e_madd);
            chk($sformatf("tbl%0d_rv", i), s_r_valid_o, tbl[i].e_rv);
            chk($sformatf("tbl%0d_rdata", i), s_r_rdata_o, tbl[i].e_rdata);
            chk($sformatf("tbl%0d_busy", i), busy_o, tbl[i].e_busy);
            s_req_i     = tbl[i].s_req;
            s_add_i     = tbl[i].s_add;
            s_wen_i     = tbl[i].s_wen;
            s_wdata_i   = tbl[i].s_add ^ 32'h1357_9BDF;
            s_be_i      = 4'hF;
            m_gnt_i     = tbl[i].m_gnt;
            m_r_valid_i = tbl[i].r_valid;
            m_r_rdata_i = tbl[i].r_rdata;
            tick();
        end

        // Outstanding limit: responses withheld, four grants then stall, one response resumes.
        sb_on = 1'b1;
        auto_resp = 1'b0;
        m_gnt_i = 1'b1;
        pop_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            drive_req(32'h1000 + 32'(i * 4), 1'b1);
            tick();
        end
        s_req_i = 1'b0;
        chk("outst_pops", 64'(pop_cnt), 4);
        chk("outst_mreq_blocked", m_req_o, 0);
        chk("outst_full_gnt", s_gnt_o, 0);
        tick();
        chk("outst_still_blocked", m_req_o, 0);
        send_resp();
        tick();
        chk("outst_resume", m_req_o, 1);
        drain("outst");

        // Back-to-back push/pop with one entry resident for 20 cycles.
        auto_resp = 1'b1;
        resp_pct = 100;
        m_gnt_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive_req($urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)));
            tick();
            chk("b2b_gnt", s_gnt_o, 1);
            chk("b2b_mreq", m_req_o, 1);
        end
        drain("b2b");

        // Clear with two queued and one outstanding.
        auto_resp = 1'b0;
        m_gnt_i = 1'b0;
        drive_req(32'h3000, 1'b1);
        tick();
        m_gnt_i = 1'b1;
        drive_req(32'h3004, 1'b1);
        tick();
        m_gnt_i = 1'b0;
        drive_req(32'h3008, 1'b0);
        tick();
        s_req_i = 1'b0;
        clear_i = 1'b1;
        tick();
        chk("clr_gnt_blocked", s_gnt_o, 0);
        drive_req(32'h300C, 1'b1);
        m_gnt_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("clr_drain_gnt", s_gnt_o, 0);
            chk("clr_drain_done", clear_done_o, 0);
        end
        chk("clr_pend3", 64'(pend.size()), 3);
        for (int k = 0; k < 3; k++) begin
            if (pend.size() > 0) send_resp();
            tick();
            chk("clr_resp_gnt", s_gnt_o, 0);
            chk("clr_resp_done", clear_done_o, 0);
        end
        tick();
        chk("clr_wait_rv", clear_done_o, 0);
        s_req_i = 1'b0;
        clear_i = 1'b0;
        tick();
        chk("clr_done_pulse", clear_done_o, 1);
        chk("clr_done_gnt", s_gnt_o, 0);
        tick();
        chk("clr_done_end", clear_done_o, 0);
        chk("clr_run_gnt", s_gnt_o, 1);
        chk("clr_sb_empty", 64'(exp_q.size()), 0);

        // Clear while idle: pulse two cycles later.
        clear_i = 1'b1;
        tick();
        chk("idle_clr_early", clear_done_o, 0);
        clear_i = 1'b0;
        tick();
        chk("idle_clr_pulse", clear_done_o, 1);
        tick();
        chk("idle_clr_end", clear_done_o, 0);

        // Random traffic with random grant stalls and response delays.
        auto_resp = 1'b1;
        resp_pct = 50;
        for (int i = 0; i < 80; i++) begin
            drive_req($urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)));
            s_req_i = 1'($urandom_range(0, 1));
            m_gnt_i = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain("rand");
        chk("rand_no_err", err_o, 0);

        // Spurious response: forwarded, sets sticky error until reset.
        sb_on = 1'b0;
        auto_resp = 1'b0;
        m_r_valid_i = 1'b1;
        m_r_rdata_i = 32'hCAFE_0001;
        tick();
        chk("err_set", err_o, 1);
        chk("err_fwd_rv", s_r_valid_o, 1);
        chk("err_fwd_rdata", s_r_rdata_o, 32'hCAFE_0001);
        repeat (3) tick();
        chk("err_sticky", err_o, 1);
        rst_i = 1'b1;
        tick();
        chk("err_cleared", err_o, 0);
        rst_i = 1'b0;
        tick();
        chk("post_rst_gnt", s_gnt_o, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
